// File: rtl/pc_seq_ctrl.sv
// pc_seq_ctrl: multi-cycle program-counter sequencer.
// Owns the PC, fetches instructions over a req/ack handshake, holds each
// instruction for the datapath until it signals completion, then selects
// the next PC (sequential, branch, jump, register jump). Handles halt and
// resume, fetch timeout and misaligned register-jump faults.
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   imem_req/addr     fetch request and address (addr is 0 when idle)
//   imem_ack/rdata    fetch completion and instruction word
//   instr/instr_valid latched instruction, valid throughout EXEC
//   exec_done, stall  datapath completion pulse and hold
//   branch_taken, jump, jr, jr_target   next-PC selection
//   halt, resume      enter/leave HALT
//   pc_out, halted    current PC, high in HALT
//   err               0 none, 1 fetch timeout, 2 misaligned target
//   retired_cnt       retired-instruction counter (wraps)
module pc_seq_ctrl #(
  parameter logic [31:0] RESET_VECTOR  = 32'h0000_0000,
  parameter int unsigned FETCH_TIMEOUT = 16,
  parameter int unsigned CNT_W         = 32
) (
  input  logic             clk,
  input  logic             rst,
  output logic             imem_req,
  output logic [31:0]      imem_addr,
  input  logic             imem_ack,
  input  logic [31:0]      imem_rdata,
  output logic [31:0]      instr,
  output logic             instr_valid,
  input  logic             exec_done,
  input  logic             stall,
  input  logic             branch_taken,
  input  logic             jump,
  input  logic             jr,
  input  logic [31:0]      jr_target,
  input  logic             halt,
  input  logic             resume,
  output logic [31:0]      pc_out,
  output logic             halted,
  output logic [1:0]       err,
  output logic [CNT_W-1:0] retired_cnt
);

  localparam int unsigned TW = $clog2(FETCH_TIMEOUT);

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_EXEC  = 2'd1,
    S_HALT  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [31:0]      pc_q, pc_d;
  logic [31:0]      instr_q, instr_d;
  logic [1:0]       err_q, err_d;
  logic [CNT_W-1:0] retired_q, retired_d;
  logic [TW-1:0]    tmo_q, tmo_d;
  // Low for the first cycle after reset so the request rises one clock
  // after reset release and any ack still in flight is ignored.
  logic             armed_q;
  // Remembers whether HALT was entered by a halt instruction (resume
  // steps past it) or by a fault (resume retries the same PC).
  logic             by_halt_q, by_halt_d;

  logic [31:0] pc4;
  logic [31:0] br_off;
  logic        req;

  assign pc4    = pc_q + 32'd4;
  assign br_off = {{14{instr_q[15]}}, instr_q[15:0], 2'b00};
  assign req    = armed_q && (state_q == S_FETCH);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_FETCH;
      pc_q      <= RESET_VECTOR;
      instr_q   <= '0;
      err_q     <= '0;
      retired_q <= '0;
      tmo_q     <= '0;
      armed_q   <= 1'b0;
      by_halt_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      instr_q   <= instr_d;
      err_q     <= err_d;
      retired_q <= retired_d;
      tmo_q     <= tmo_d;
      armed_q   <= 1'b1;
      by_halt_q <= by_halt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    instr_d   = instr_q;
    err_d     = err_q;
    retired_d = retired_q;
    tmo_d     = tmo_q;
    by_halt_d = by_halt_q;

    case (state_q)
      S_FETCH: begin
        if (armed_q) begin
          if (imem_ack) begin
            instr_d = imem_rdata;
            tmo_d   = '0;
            state_d = S_EXEC;
          end else if (tmo_q == TW'(FETCH_TIMEOUT - 1)) begin
            err_d     = 2'd1;
            by_halt_d = 1'b0;
            tmo_d     = '0;
            state_d   = S_HALT;
          end else begin
            tmo_d = tmo_q + TW'(1);
          end
        end
      end

      S_EXEC: begin
        if (exec_done && !stall) begin
          if (halt) begin
            by_halt_d = 1'b1;
            retired_d = retired_q + CNT_W'(1);
            state_d   = S_HALT;
          end else if (jr && (jr_target[1:0] != 2'b00)) begin
            err_d     = 2'd2;
            by_halt_d = 1'b0;
            state_d   = S_HALT;
          end else begin
            if (jr) begin
              pc_d = jr_target;
            end else if (jump) begin
              pc_d = {pc4[31:28], instr_q[25:0], 2'b00};
            end else if (branch_taken) begin
              pc_d = pc4 + br_off;
            end else begin
              pc_d = pc4;
            end
            retired_d = retired_q + CNT_W'(1);
            state_d   = S_FETCH;
          end
        end
      end

      S_HALT: begin
        if (resume) begin
          err_d   = '0;
          state_d = S_FETCH;
          if (by_halt_q) begin
            pc_d = pc4;
          end
        end
      end

      default: state_d = S_FETCH;
    endcase
  end

  assign imem_req    = req;
  assign imem_addr   = req ? pc_q : '0;
  assign instr       = instr_q;
  assign instr_valid = (state_q == S_EXEC);
  assign pc_out      = pc_q;
  assign halted      = (state_q == S_HALT);
  assign err         = err_q;
  assign retired_cnt = retired_q;

endmodule
